// File: rtl/sha256_pad_ctrl.sv
// SHA-256 front end: packs a byte stream into 512-bit blocks, appends FIPS 180-4
// padding and the big-endian bit length, and hands blocks to the core over valid/ready.
module sha256_pad_ctrl #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         byte_rdy,
    input  logic         byte_stop,
    input  logic [7:0]   data_in,
    input  logic         blk_ready,
    output logic         blk_valid,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    output logic         overflow,
    output logic         msg_done
);

    localparam int unsigned PTR_W = 6;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(63);
    localparam logic [PTR_W-1:0] PTR_LEN  = PTR_W'(56);

    typedef enum logic [2:0] {IDLE, LOAD, PAD, ZERO, LEN, ISSUE, DONE} state_t;

    state_t             state, state_d;
    logic [PTR_W-1:0]   ptr, ptr_d;
    logic [LEN_W-1:0]   bitlen, bitlen_d;
    logic               first_flag, first_flag_d;
    logic               ret_zero, ret_zero_d;
    logic               blk_valid_d, blk_first_d, blk_last_d, overflow_d, msg_done_d;
    logic [511:0]       blk_data_d;

    logic [LEN_W:0]     bitlen_inc_c;
    logic [8:0]         byte_lsb_c;
    logic               xfer_c;

    assign bitlen_inc_c = (LEN_W+1)'(bitlen) + (LEN_W+1)'(8);
    // Byte 0 lands in the top byte lane of the block.
    assign byte_lsb_c   = 9'd504 - {ptr, 3'b000};
    assign xfer_c       = blk_valid & blk_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            bitlen     <= '0;
            first_flag <= 1'b1;
            ret_zero   <= 1'b0;
            blk_valid  <= 1'b0;
            blk_data   <= '0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            overflow   <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            bitlen     <= bitlen_d;
            first_flag <= first_flag_d;
            ret_zero   <= ret_zero_d;
            blk_valid  <= blk_valid_d;
            blk_data   <= blk_data_d;
            blk_first  <= blk_first_d;
            blk_last   <= blk_last_d;
            overflow   <= overflow_d;
            msg_done   <= msg_done_d;
        end
    end

    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        bitlen_d     = bitlen;
        first_flag_d = first_flag;
        ret_zero_d   = ret_zero;
        blk_valid_d  = blk_valid;
        blk_data_d   = blk_data;
        blk_first_d  = blk_first;
        blk_last_d   = blk_last;
        overflow_d   = overflow;
        msg_done_d   = 1'b0;

        // Bytes offered while not loading are dropped and flagged.
        if (byte_rdy && !(state inside {IDLE, LOAD})) overflow_d = 1'b1;

        case (state)
            IDLE, LOAD: begin
                if (byte_rdy) begin
                    blk_data_d[byte_lsb_c +: 8] = data_in;
                    ptr_d    = ptr + PTR_W'(1);
                    bitlen_d = bitlen_inc_c[LEN_W-1:0];
                    if (bitlen_inc_c[LEN_W]) overflow_d = 1'b1;
                    state_d  = LOAD;
                    if (ptr == PTR_LAST) begin
                        state_d     = ISSUE;
                        blk_valid_d = 1'b1;
                        blk_first_d = first_flag;
                        blk_last_d  = 1'b0;
                        ret_zero_d  = 1'b0;
                    end
                end else if (byte_stop) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                blk_data_d[byte_lsb_c +: 8] = 8'h80;
                ptr_d   = ptr + PTR_W'(1);
                state_d = ZERO;
                if (ptr == PTR_LAST) begin
                    state_d     = ISSUE;
                    blk_valid_d = 1'b1;
                    blk_first_d = first_flag;
                    blk_last_d  = 1'b0;
                    ret_zero_d  = 1'b1;
                end
            end
            ZERO: begin
                // Buffer is already zero after reset/transfer, so only the pointer moves.
                if (ptr == PTR_LEN) begin
                    state_d = LEN;
                end else begin
                    ptr_d = ptr + PTR_W'(1);
                    if (ptr == PTR_LAST) begin
                        state_d     = ISSUE;
                        blk_valid_d = 1'b1;
                        blk_first_d = first_flag;
                        blk_last_d  = 1'b0;
                        ret_zero_d  = 1'b1;
                    end
                end
            end
            LEN: begin
                blk_data_d[63:0] = 64'(bitlen);
                state_d     = ISSUE;
                blk_valid_d = 1'b1;
                blk_first_d = first_flag;
                blk_last_d  = 1'b1;
                ret_zero_d  = 1'b0;
            end
            ISSUE: begin
                if (xfer_c) begin
                    first_flag_d = 1'b0;
                    blk_valid_d  = 1'b0;
                    blk_first_d  = 1'b0;
                    blk_last_d   = 1'b0;
                    blk_data_d   = '0;
                    ptr_d        = '0;
                    if (blk_last) begin
                        state_d    = DONE;
                        msg_done_d = 1'b1;
                    end else if (ret_zero) begin
                        state_d = ZERO;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                if (!byte_stop) begin
                    state_d      = IDLE;
                    bitlen_d     = '0;
                    first_flag_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// Scoreboard bench for sha256_pad_ctrl: expected padded blocks are built from each
// message when it is driven and compared as the DUT presents/transfers them.
module tb_sha256_pad_ctrl;

    logic         clk = 1'b0;
    logic         rst, byte_rdy, byte_stop, blk_ready;
    logic [7:0]   data_in;
    logic         blk_valid, blk_first, blk_last, overflow, msg_done;
    logic [511:0] blk_data;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_done = 1'b0;

    sha256_pad_ctrl #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_rdy  (byte_rdy),
        .byte_stop (byte_stop),
        .data_in   (data_in),
        .blk_ready (blk_ready),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .overflow  (overflow),
        .msg_done  (msg_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference padding: message, 0x80, zeros, 64-bit big-endian bit length.
    task automatic push_expected(input byte unsigned m[$]);
        int unsigned  len;
        int unsigned  nblk;
        byte unsigned p[];
        logic [63:0]  bits;
        exp_t         e;
        len  = m.size();
        nblk = (len + 8) / 64 + 1;
        p    = new[nblk * 64];
        foreach (p[i]) p[i] = 8'h00;
        for (int i = 0; i < int'(len); i++) p[i] = m[i];
        p[len] = 8'h80;
        bits = 64'(len) * 64'd8;
        for (int k = 0; k < 8; k++) p[nblk*64 - 8 + k] = bits[63 - 8*k -: 8];
        for (int b = 0; b < int'(nblk); b++) begin
            e.data = '0;
            for (int i = 0; i < 64; i++) e.data[511 - 8*i -: 8] = p[b*64 + i];
            e.first = (b == 0);
            e.last  = (b == int'(nblk) - 1);
            sb.push_back(e);
        end
    endtask

    // Monitor: outputs sampled on the falling edge; a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (exp_done || msg_done) chk("msg_done", 512'(msg_done), 512'(exp_done));
        exp_done = 1'b0;
        if (rst && blk_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 512'(blk_valid), 512'(0));
            end else begin
                chk("blk_data",  blk_data, sb[0].data);
                chk("blk_first", 512'(blk_first), 512'(sb[0].first));
                chk("blk_last",  512'(blk_last),  512'(sb[0].last));
                if (blk_ready) begin
                    exp_done = sb[0].last;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input byte unsigned m[$], input bit stop_on_last);
        for (int i = 0; i < m.size(); i++) begin
            byte_rdy  = 1'b1;
            data_in   = m[i];
            byte_stop = stop_on_last && (i == m.size() - 1);
            tick();
        end
        byte_rdy = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 512'(sb.size()), 512'(0));
        tick();
        tick();
        byte_stop = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned m[$];
        int n;
        rst = 1'b0; byte_rdy = 1'b0; byte_stop = 1'b0; data_in = 8'h00; blk_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid",    512'(blk_valid), 512'(0));
        chk("rst_data",     blk_data, 512'(0));
        chk("rst_first",    512'(blk_first), 512'(0));
        chk("rst_last",     512'(blk_last), 512'(0));
        chk("rst_overflow", 512'(overflow), 512'(0));
        chk("rst_done",     512'(msg_done), 512'(0));
        rst = 1'b1;
        tick();

        // Empty message
        m = {};
        push_expected(m);
        byte_stop = 1'b1;
        tick();
        byte_stop = 1'b0;
        drain(200);

        // "abc" with stop-to-valid latency: r=3 -> valid rises 55 edges after the stop edge
        m = '{8'h61, 8'h62, 8'h63};
        push_expected(m);
        send_bytes(m, 1'b0);
        byte_stop = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!blk_valid && n < 200);
        chk("abc_latency", 512'(n), 512'(56));
        drain(200);

        // 56-byte message spills padding into a second block
        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'(i + 1));
        push_expected(m);
        send_bytes(m, 1'b0);
        byte_stop = 1'b1;
        drain(300);

        // 64-byte message with the core stalled; bytes offered during the stall are dropped
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i * 3 + 7));
        push_expected(m);
        blk_ready = 1'b0;
        send_bytes(m, 1'b0);
        chk("stall_valid",  512'(blk_valid), 512'(1));
        chk("ovf_pre",      512'(overflow), 512'(0));
        for (int i = 0; i < 10; i++) begin
            byte_rdy = 1'b1;
            data_in  = 8'hEE;
            tick();
        end
        byte_rdy = 1'b0;
        chk("ovf_stall", 512'(overflow), 512'(1));
        chk("stall_valid_held", 512'(blk_valid), 512'(1));
        blk_ready = 1'b1;
        byte_stop = 1'b1;
        drain(300);
        chk("ovf_sticky", 512'(overflow), 512'(1));

        // Final byte together with stop; stop then held so DONE must not restart
        m = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        push_expected(m);
        send_bytes(m, 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("stopbyte_drained", 512'(sb.size()), 512'(0));
        for (int i = 0; i < 20; i++) tick();
        chk("done_hold_valid", 512'(blk_valid), 512'(0));
        byte_stop = 1'b0;
        tick();

        // Reset mid-message discards buffered bytes and clears overflow
        m = {};
        for (int i = 0; i < 20; i++) m.push_back(8'(8'hA0 + i));
        send_bytes(m, 1'b0);
        rst = 1'b0;
        tick();
        chk("mid_rst_valid",    512'(blk_valid), 512'(0));
        chk("mid_rst_data",     blk_data, 512'(0));
        chk("mid_rst_overflow", 512'(overflow), 512'(0));
        chk("mid_rst_flags",    512'({blk_first, blk_last, msg_done}), 512'(0));
        rst = 1'b1;
        tick();
        m = '{8'h00};
        push_expected(m);
        send_bytes(m, 1'b1);
        drain(200);
        chk("final_overflow", 512'(overflow), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
